// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and condition-code encodings.
package lc3_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_idx_t;
    typedef logic [2:0]  nzp_t;

    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

endpackage

// File: rtl/reg_file_cc_nzp_gen.sv
// nzp_gen: combinational classification of a bus word into one-hot {N,Z,P}.
module nzp_gen
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_word,
    output nzp_t              o_nzp
);

    always_comb begin
        o_nzp = NZP_Z;
        if (i_word[DATA_W-1]) begin
            o_nzp = NZP_N;
        end else if (i_word != '0) begin
            o_nzp = NZP_P;
        end
    end

endmodule

// File: rtl/reg_file_cc.sv
// reg_file_cc: LC-3 register file with NZP condition codes and branch enable.
// Optional write-through read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_cc
    import lc3_pkg::*;
#(
    parameter  int unsigned DATA_W   = 16,
    parameter  int unsigned NUM_REGS = 8,
    localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_REG,
    input  logic [REG_AW-1:0] DR,
    input  logic [DATA_W-1:0] Bus_In,
    input  logic [REG_AW-1:0] SR1,
    input  logic [REG_AW-1:0] SR2,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic [2:0]        IR_NZP,
    output logic [DATA_W-1:0] SR1_Out,
    output logic [DATA_W-1:0] SR2_Out,
    output logic [2:0]        NZP,
    output logic              BEN
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    nzp_t              r_nzp;
    logic              r_ben;
    nzp_t              w_bus_nzp;

    nzp_gen #(
        .DATA_W (DATA_W)
    ) u_nzp_gen (
        .i_word (Bus_In),
        .o_nzp  (w_bus_nzp)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (LD_REG) begin
            r_regs[DR] <= Bus_In;
        end
    end

    // BEN samples r_nzp before this edge, so a concurrent LD_CC is not seen.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_nzp <= NZP_Z;
            r_ben <= 1'b0;
        end else begin
            if (LD_CC) begin
                r_nzp <= w_bus_nzp;
            end
            if (LD_BEN) begin
                r_ben <= |(IR_NZP & r_nzp);
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        SR1_Out = r_regs[SR1];
        SR2_Out = r_regs[SR2];
        if (LD_REG && (DR == SR1)) begin
            SR1_Out = Bus_In;
        end
        if (LD_REG && (DR == SR2)) begin
            SR2_Out = Bus_In;
        end
    end
`else
    always_comb begin
        SR1_Out = r_regs[SR1];
        SR2_Out = r_regs[SR2];
    end
`endif

    assign NZP = r_nzp;
    assign BEN = r_ben;

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed and scoreboard-checked bench for reg_file_cc (either REGFILE_BYPASS_EN build).
module tb_reg_file_cc;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] Bus_In;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic        LD_CC;
    logic        LD_BEN;
    logic [2:0]  IR_NZP;
    logic [15:0] SR1_Out;
    logic [15:0] SR2_Out;
    logic [2:0]  NZP;
    logic        BEN;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_cc #(
        .DATA_W   (16),
        .NUM_REGS (8)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .LD_REG  (LD_REG),
        .DR      (DR),
        .Bus_In  (Bus_In),
        .SR1     (SR1),
        .SR2     (SR2),
        .LD_CC   (LD_CC),
        .LD_BEN  (LD_BEN),
        .IR_NZP  (IR_NZP),
        .SR1_Out (SR1_Out),
        .SR2_Out (SR2_Out),
        .NZP     (NZP),
        .BEN     (BEN)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [2:0] ref_nzp(input logic [15:0] w);
        if (w == 16'h0000)       return 3'b010;
        else if (w >= 16'h8000)  return 3'b100;
        else                     return 3'b001;
    endfunction

    logic [15:0] m_regs [8];
    logic [2:0]  m_nzp;
    logic        m_ben;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic [15:0] bus_tab [4] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};
    logic [2:0]  nzp_tab [4] = '{3'b100, 3'b010, 3'b001, 3'b100};

    initial begin
        Reset = 1'b0; LD_REG = 1'b0; DR = '0; Bus_In = '0; SR1 = '0; SR2 = '0;
        LD_CC = 1'b0; LD_BEN = 1'b0; IR_NZP = '0;
        @(negedge Clk);

        // 1: reset overrides concurrent loads
        Reset = 1'b1; LD_REG = 1'b1; DR = 3'd3; Bus_In = 16'hBEEF;
        LD_CC = 1'b1; LD_BEN = 1'b1; IR_NZP = 3'b111;
        tick();
        Reset = 1'b0; LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(7 - i);
            #1;
            check("rst_sr1", SR1_Out, 16'h0000);
            check("rst_sr2", SR2_Out, 16'h0000);
        end
        check("rst_nzp", {13'b0, NZP}, 16'h0002);
        check("rst_ben", {15'b0, BEN}, 16'h0000);

        // 2: write R5 then read on both ports
        LD_REG = 1'b1; DR = 3'd5; Bus_In = 16'h1234;
        tick();
        LD_REG = 1'b0; SR1 = 3'd5; SR2 = 3'd5;
        #1;
        check("r5_sr1", SR1_Out, 16'h1234);
        check("r5_sr2", SR2_Out, 16'h1234);
        for (int i = 0; i < 8; i++) begin
            if (i != 5) begin
                SR2 = 3'(i);
                #1;
                check("r5_others", SR2_Out, 16'h0000);
            end
        end

        // 3: same-cycle write/read of R2
        LD_REG = 1'b1; DR = 3'd2; Bus_In = 16'hA5A5; SR1 = 3'd2; SR2 = 3'd0;
        #1;
        check("byp_sr1", SR1_Out, BYPASS ? 16'hA5A5 : 16'h0000);
        check("byp_sr2", SR2_Out, 16'h0000);
        tick();
        LD_REG = 1'b0;
        #1;
        check("r2_after", SR1_Out, 16'hA5A5);

        // 4: NZP boundary values
        for (int i = 0; i < 4; i++) begin
            LD_CC = 1'b1; Bus_In = bus_tab[i];
            tick();
            check("cc_tab", {13'b0, NZP}, {13'b0, nzp_tab[i]});
        end
        LD_CC = 1'b0;

        // 5: BEN uses pre-edge NZP
        LD_CC = 1'b1; Bus_In = 16'h0001;
        tick();
        check("cc_p", {13'b0, NZP}, 16'h0001);
        Bus_In = 16'h0000; LD_BEN = 1'b1; IR_NZP = 3'b001;
        tick();
        check("ben_old_p", {15'b0, BEN}, 16'h0001);
        check("cc_z", {13'b0, NZP}, 16'h0002);
        LD_CC = 1'b0;
        tick();
        check("ben_z_vs_p", {15'b0, BEN}, 16'h0000);
        IR_NZP = 3'b111;
        tick();
        check("ben_111", {15'b0, BEN}, 16'h0001);
        IR_NZP = 3'b000;
        tick();
        check("ben_000", {15'b0, BEN}, 16'h0000);
        LD_BEN = 1'b0;

        // 6: random traffic against a scoreboard
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_nzp = 3'b010;
        m_ben = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            Reset  = (c == 3000) || (c == 7000) || ($urandom_range(0, 499) == 0);
            LD_REG = 1'($urandom_range(0, 1));
            LD_CC  = 1'($urandom_range(0, 1));
            LD_BEN = 1'($urandom_range(0, 1));
            DR     = 3'($urandom_range(0, 7));
            SR1    = 3'($urandom_range(0, 7));
            SR2    = 3'($urandom_range(0, 7));
            IR_NZP = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       Bus_In = 16'h0000;
                1:       Bus_In = 16'h8000;
                2:       Bus_In = 16'h7FFF;
                default: Bus_In = 16'($urandom);
            endcase
            #1;
            exp1 = (BYPASS && LD_REG && DR == SR1) ? Bus_In : m_regs[SR1];
            exp2 = (BYPASS && LD_REG && DR == SR2) ? Bus_In : m_regs[SR2];
            check("rnd_sr1", SR1_Out, exp1);
            check("rnd_sr2", SR2_Out, exp2);
            check("rnd_nzp", {13'b0, NZP}, {13'b0, m_nzp});
            check("rnd_ben", {15'b0, BEN}, {15'b0, m_ben});
            check("rnd_onehot", 16'($countones(NZP)), 16'd1);
            tick();
            if (Reset) begin
                for (int i = 0; i < 8; i++) m_regs[i] = '0;
                m_nzp = 3'b010;
                m_ben = 1'b0;
            end else begin
                if (LD_REG) m_regs[DR] = Bus_In;
                if (LD_BEN) m_ben = |(IR_NZP & m_nzp);
                if (LD_CC)  m_nzp = ref_nzp(Bus_In);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
